// File: rtl/non_strict_elastic_buffer_if.sv
// Write/read handshake bundle for the elastic buffer.
// A word moves on a rising edge only when valid && ready are both high on that side.
// valid may be raised without waiting for ready, and ready may depend combinationally on local state.
interface non_strict_elastic_buffer_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_valid,
    output out_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_valid,
    input  out_ready
  );
endinterface

// File: rtl/non_strict_elastic_buffer.sv
// First-word-fall-through circular buffer with occupancy and peak-occupancy tracking.
// Every path from input to output goes through storage, so the minimum latency is one cycle.
module non_strict_elastic_buffer #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 16,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  non_strict_elastic_buffer_if.slave    bus,
  output logic [CW-1:0]                 count,
  output logic [CW-1:0]                 peak,
  output logic                          full,
  output logic                          empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_next;
  logic [CW-1:0]    peak_next;
  logic             wr_en;
  logic             rd_en;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full          = (count == CW'(DEPTH));
  assign empty         = (count == '0);
  assign bus.in_ready  = !full && !flush;
  assign bus.out_valid = !empty;
  assign bus.out_data  = mem[rd_ptr];

  // Blocking writes while flush is high keeps them out of the flush cycle.
  assign wr_en = bus.in_valid && bus.in_ready;
  assign rd_en = bus.out_valid && bus.out_ready;

  always_comb begin
    count_next = count;
    case ({wr_en, rd_en})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
    peak_next = (count_next > peak) ? count_next : peak;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count  <= '0;
      peak   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      count <= count_next;
      peak  <= peak_next;
      if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  // Storage is not reset; stale entries are unreachable once the pointers return to zero.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= bus.in_data;
  end

endmodule

// File: tb/tb_non_strict_elastic_buffer.sv
// Directed and random stimulus against a queue-based model of the elastic buffer.
module tb_non_strict_elastic_buffer;

  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          rst;
  logic          flush;
  logic [CW-1:0] count;
  logic [CW-1:0] peak;
  logic          full;
  logic          empty;

  non_strict_elastic_buffer_if #(.WIDTH(WIDTH)) bus ();

  non_strict_elastic_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus),
    .count (count),
    .peak  (peak),
    .full  (full),
    .empty (empty)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // scoreboard
  logic [WIDTH-1:0] exp_q[$];
  int               mpeak;
  int               vectors;
  int               errors;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks: called at the falling edge, return at the next falling edge
  task automatic cycle(input logic iv, input logic [WIDTH-1:0] d, input logic ordy, input logic fl);
    logic rd;
    logic wr;
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    flush         = fl;
    #1;
    check("in_ready", 32'(bus.in_ready), 32'((exp_q.size() < DEPTH) && !fl));
    check("out_valid", 32'(bus.out_valid), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) check("out_data", bus.out_data, exp_q[0]);
    check("count", 32'(count), 32'(exp_q.size()));
    check("peak", 32'(peak), 32'(mpeak));
    check("full", 32'(full), 32'(exp_q.size() == DEPTH));
    check("empty", 32'(empty), 32'(exp_q.size() == 0));
    @(posedge clk);
    if (fl) begin
      exp_q.delete();
      mpeak = 0;
    end else begin
      rd = (exp_q.size() > 0) && ordy;
      wr = iv && (exp_q.size() < DEPTH);
      if (rd) void'(exp_q.pop_front());
      if (wr) exp_q.push_back(d);
      if (exp_q.size() > mpeak) mpeak = exp_q.size();
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input logic iv);
    rst           = 1'b1;
    bus.in_valid  = iv;
    bus.in_data   = 32'hDEAD_BEEF;
    bus.out_ready = 1'b1;
    flush         = 1'b1;
    @(posedge clk);
    exp_q.delete();
    mpeak = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    mpeak   = 0;
    rst     = 1'b1;
    flush   = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    @(negedge clk);

    // reset state, with a write request held during reset
    do_reset(1'b1);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);

    // fill 0..15, then a 17th request that must be ignored
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'(i), 1'b0, 1'b0);
    cycle(1'b1, 32'h99, 1'b0, 1'b0);
    check("fill_peak", 32'(peak), 32'(DEPTH));

    // drain in order, peak holds
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    check("drain_peak", 32'(peak), 32'(DEPTH));

    // full with simultaneous read: read only, write lands next cycle
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);
    cycle(1'b1, 32'h1234_5678, 1'b1, 1'b0);
    check("full_rd_count", 32'(count), 32'(DEPTH - 1));
    cycle(1'b1, 32'h1234_5678, 1'b0, 1'b0);
    check("full_rd_refill", 32'(count), 32'(DEPTH));

    // flush at count 5 with both sides active
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'(100 + i), 1'b0, 1'b0);
    cycle(1'b1, 32'hF1F1, 1'b1, 1'b1);
    check("flush_count", 32'(count), 32'd0);
    check("flush_peak", 32'(peak), 32'd0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // streaming: 100 words with both sides continuously active
    for (int i = 0; i < 100; i++) cycle(1'b1, $urandom, 1'b1, 1'b0);
    check("stream_count", 32'(count), 32'd1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // reset mid-transfer at count 7, then 0xA5 must be the first word out
    for (int i = 0; i < 7; i++) cycle(1'b1, 32'(200 + i), 1'b0, 1'b0);
    check("pre_rst_count", 32'(count), 32'd7);
    do_reset(1'b0);
    cycle(1'b1, 32'hA5, 1'b0, 1'b0);
    check("post_rst_head", bus.out_data, 32'hA5);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // random traffic with occasional flush
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 40) == 0));
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
    check("final_empty", 32'(empty), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
